// File: rtl/decoder_nx2n_scan.sv
// Registered N-to-2^N one-hot decoder: DIRECT decodes handshaked indices, SCAN sweeps a prescaled index.
// One cycle from accept/tick to out_valid; a one-beat output register stalls the input and scan when full.
module decoder_nx2n_scan #(
  parameter int N          = 4,
  parameter int SCAN_DIV   = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0]        in_idx,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [(1<<N)-1:0]   out_d,
  output logic [N-1:0]        out_idx,
  output logic                out_last
);

  localparam int OUT_W = 1 << N;
  localparam int PW    = $clog2(SCAN_DIV + 1);
  localparam logic [PW-1:0]    PSC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [N-1:0]     IDX_MAX  = {N{1'b1}};
  localparam logic [OUT_W-1:0] OUT_IDLE = {OUT_W{ACTIVE_LOW != 0}};

  typedef enum logic {S_DIRECT = 1'b0, S_SCAN = 1'b1} state_t;

  state_t           state_q;
  logic [PW-1:0]    psc_q;
  logic [N-1:0]     scan_idx_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_d_q;
  logic [N-1:0]     out_idx_q;
  logic             out_last_q;

  logic             can_load;
  logic             scan_tick;
  logic             load;
  logic [N-1:0]     idx_d;
  logic             last_d;

  function automatic logic [OUT_W-1:0] encode(input logic [N-1:0] idx);
    logic [OUT_W-1:0] oh;
    oh = {{(OUT_W-1){1'b0}}, 1'b1} << idx;
    return (ACTIVE_LOW != 0) ? ~oh : oh;
  endfunction

  always_comb begin
    can_load  = en && (!out_valid_q || out_ready);
    in_ready  = (state_q == S_DIRECT) && can_load;
    scan_tick = (state_q == S_SCAN) && en && (psc_q == PSC_LAST);
    load      = (in_valid && in_ready) || (scan_tick && can_load);
    idx_d     = (state_q == S_SCAN) ? scan_idx_q : in_idx;
    last_d    = (state_q == S_SCAN) && (scan_idx_q == IDX_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_DIRECT;
      psc_q       <= '0;
      scan_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_d_q     <= OUT_IDLE;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (load) begin
        out_valid_q <= 1'b1;
        out_d_q     <= encode(idx_d);
        out_idx_q   <= idx_d;
        out_last_q  <= last_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        S_DIRECT: begin
          if (mode) begin
            state_q    <= S_SCAN;
            psc_q      <= '0;
            scan_idx_q <= '0;
          end
        end
        S_SCAN: begin
          if (scan_tick && can_load) scan_idx_q <= scan_idx_q + 1'b1;
          // A stalled tick parks the prescaler on its last count until the beat can load.
          if (!mode) begin
            state_q <= S_DIRECT;
            psc_q   <= '0;
          end else if (en && (psc_q != PSC_LAST)) begin
            psc_q <= psc_q + 1'b1;
          end else if (scan_tick && can_load) begin
            psc_q <= '0;
          end
        end
        default: state_q <= S_DIRECT;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_d     = out_d_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_decoder_nx2n_scan.sv
// Directed bench: table-driven DIRECT vectors plus hand-written SCAN, stall, enable and reset sequences.
module tb_decoder_nx2n_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst, en, mode, in_valid, out_ready;
  logic [3:0]  in_idx;
  logic        in_ready, out_valid, out_last;
  logic [15:0] out_d;
  logic [3:0]  out_idx;

  logic        b_en, b_mode, b_in_valid, b_out_ready;
  logic [2:0]  b_in_idx;
  logic        b_in_ready, b_out_valid, b_out_last;
  logic [7:0]  b_out_d;
  logic [2:0]  b_out_idx;

  decoder_nx2n_scan #(.N(4), .SCAN_DIV(4), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_d(out_d), .out_idx(out_idx), .out_last(out_last)
  );

  decoder_nx2n_scan #(.N(3), .SCAN_DIV(1), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst(rst), .en(b_en), .mode(b_mode),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_idx(b_in_idx),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_d(b_out_d), .out_idx(b_out_idx), .out_last(b_out_last)
  );

  typedef struct {
    logic        in_valid;
    logic [3:0]  in_idx;
    logic        out_ready;
    logic        exp_in_ready;
    logic        exp_valid;
    logic [15:0] exp_d;
    logic [3:0]  exp_idx;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic iv, input logic [3:0] ii, input logic ordy,
                              input logic eir, input logic ev, input logic [15:0] ed,
                              input logic [3:0] ei);
    vec_t v;
    v.in_valid = iv; v.in_idx = ii; v.out_ready = ordy;
    v.exp_in_ready = eir; v.exp_valid = ev; v.exp_d = ed; v.exp_idx = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a(input string name, input int exp_n);
    int n = 0;
    do begin
      step();
      n++;
    end while (!out_valid && n < 20);
    chk({name, " cycles"}, n, exp_n);
  endtask

  task automatic wait_b(input string name, input int exp_n);
    int n = 0;
    do begin
      step();
      n++;
    end while (!b_out_valid && n < 20);
    chk({name, " cycles"}, n, exp_n);
  endtask

  task automatic chk_a_beat(input string name, input int k);
    logic [15:0] e;
    e = 16'h0001 << k;
    chk({name, " valid"}, out_valid, 1);
    chk({name, " idx"}, out_idx, k);
    chk({name, " d"}, out_d, e);
    chk({name, " last"}, out_last, (k == 15));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ea;
    logic [7:0]  eb;
    rst = 1'b1; en = 1'b1; mode = 1'b0; in_valid = 1'b0; in_idx = '0; out_ready = 1'b0;
    b_en = 1'b1; b_mode = 1'b0; b_in_valid = 1'b0; b_in_idx = '0; b_out_ready = 1'b0;
    #7;
    chk("rst a valid", out_valid, 0);
    chk("rst a d", out_d, 16'h0000);
    chk("rst a idx", out_idx, 0);
    chk("rst a last", out_last, 0);
    chk("rst b valid", b_out_valid, 0);
    chk("rst b d", b_out_d, 8'hFF);
    #5 rst = 1'b0;
    step();
    chk("idle a in_ready", in_ready, 1);

    // DIRECT back-to-back, drain, then stall/release
    for (int k = 0; k < 16; k++) begin
      ea = 16'h0001 << k;
      vecs.push_back(mk(1'b1, 4'(k), 1'b1, 1'b1, 1'b1, ea, 4'(k)));
    end
    vecs.push_back(mk(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 16'h8000, 4'd15));
    vecs.push_back(mk(1'b1, 4'd5, 1'b1, 1'b1, 1'b1, 16'h0020, 4'd5));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1'b1, 4'd9, 1'b0, 1'b0, 1'b1, 16'h0020, 4'd5));
    vecs.push_back(mk(1'b1, 4'd9, 1'b1, 1'b1, 1'b1, 16'h0200, 4'd9));
    vecs.push_back(mk(1'b0, 4'd9, 1'b1, 1'b1, 1'b0, 16'h0200, 4'd9));

    foreach (vecs[i]) begin
      in_valid  = vecs[i].in_valid;
      in_idx    = vecs[i].in_idx;
      out_ready = vecs[i].out_ready;
      #1;
      chk($sformatf("v%0d in_ready", i), in_ready, vecs[i].exp_in_ready);
      step();
      chk($sformatf("v%0d valid", i), out_valid, vecs[i].exp_valid);
      chk($sformatf("v%0d d", i), out_d, vecs[i].exp_d);
      chk($sformatf("v%0d idx", i), out_idx, vecs[i].exp_idx);
      chk($sformatf("v%0d last", i), out_last, 0);
    end
    in_valid = 1'b0;

    // SCAN sweep with wrap
    mode = 1'b1;
    out_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      wait_a($sformatf("scan%0d", j), (j == 0) ? 5 : 4);
      chk_a_beat($sformatf("scan%0d", j), j % 16);
    end

    // Stall on idx 3
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk_a_beat($sformatf("stall%0d", k), 3);
    end
    out_ready = 1'b1;
    wait_a("release", 1);
    chk_a_beat("release", 4);
    wait_a("after release", 4);
    chk_a_beat("after release", 5);

    // en=0 freezes the prescaler
    step();
    chk("pre-freeze valid", out_valid, 0);
    en = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      chk($sformatf("frozen%0d valid", k), out_valid, 0);
    end
    en = 1'b1;
    wait_a("unfreeze", 3);
    chk_a_beat("unfreeze", 6);

    // mode 1->0->1 restarts the scan at 0
    mode = 1'b0;
    step();
    chk("direct again in_ready", in_ready, 1);
    en = 1'b0;
    #1;
    chk("en0 in_ready", in_ready, 0);
    en = 1'b1;
    mode = 1'b1;
    wait_a("rescan", 5);
    chk_a_beat("rescan", 0);

    // Async reset between edges with a pending beat
    out_ready = 1'b0;
    #3;
    chk("a pre-rst valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("a async rst valid", out_valid, 0);
    chk("a async rst d", out_d, 16'h0000);
    chk("a async rst idx", out_idx, 0);
    chk("a async rst last", out_last, 0);
    #1 rst = 1'b0;
    mode = 1'b0;
    step();
    chk("a post-rst in_ready", in_ready, 1);
    chk("a post-rst valid", out_valid, 0);

    // N=3, SCAN_DIV=1, ACTIVE_LOW=1: one step per cycle
    b_mode = 1'b1;
    b_out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_b($sformatf("b scan%0d", k), (k == 0) ? 2 : 1);
      eb = ~(8'h01 << (k % 8));
      chk($sformatf("b scan%0d idx", k), b_out_idx, k % 8);
      chk($sformatf("b scan%0d d", k), b_out_d, eb);
      chk($sformatf("b scan%0d last", k), b_out_last, ((k % 8) == 7));
    end
    b_out_ready = 1'b0;
    #3;
    chk("b pre-rst valid", b_out_valid, 1);
    rst = 1'b1;
    #1;
    chk("b async rst valid", b_out_valid, 0);
    chk("b async rst d", b_out_d, 8'hFF);
    chk("b async rst idx", b_out_idx, 0);
    #1 rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
